// File: rtl/ps2_key_ctrl_pkg.sv
// Shared types and constants for the PS/2 key-event sequencer.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_key_ctrl_evt_fifo.sv
// Synchronous show-ahead FIFO; push while full is accepted only with a same-cycle pop.
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code prefix stripper feeding an event FIFO and the display byte.
// Optional PS2_TIMEOUT_EN abandons a partial prefix after TIMEOUT_CYCLES idle cycles.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [7:0] disp_code,
    output logic       overflow,
    output logic       busy
);
    ps2_state_e state, state_nxt;
    ps2_evt_t   evt_new, head, shown;
    logic       emit, pop, fifo_full, fifo_empty;

`ifdef PS2_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;
    assign to_hit = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_nxt    = state;
        emit         = 1'b0;
        evt_new.ext  = (state == EXT) || (state == EXT_BRK);
        evt_new.brk  = (state == BRK) || (state == EXT_BRK);
        evt_new.code = rx_data;
        if (rx_valid) begin
            if (rx_data == PS2_ERR0 || rx_data == PS2_ERR1) begin
                state_nxt = IDLE;
            end else if (rx_data == PS2_EXT) begin
                state_nxt = EXT;
            end else if (rx_data == PS2_BRK) begin
                // F0 after a lone E0 keeps the extended flag; otherwise it starts a plain break.
                state_nxt = (state == EXT) ? EXT_BRK : BRK;
            end else begin
                emit      = 1'b1;
                state_nxt = IDLE;
            end
        end
`ifdef PS2_TIMEOUT_EN
        else if (to_hit) begin
            state_nxt = IDLE;
        end
`endif
    end

    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ps2_evt_t))
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (emit),
        .wr_data (evt_new),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign shown     = evt_valid ? head : '0;
    assign evt_code  = shown.code;
    assign evt_ext   = shown.ext;
    assign evt_break = shown.brk;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            disp_code <= 8'h00;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            if (emit && !evt_new.brk)          disp_code <= rx_data;
            if (emit && fifo_full && !pop)     overflow  <= 1'b1;
        end
    end

`ifdef PS2_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset || rx_valid || state_nxt == IDLE) to_cnt <= '0;
        else                                        to_cnt <= to_cnt + TO_W'(1);
    end
`endif

endmodule
